// File: rtl/prism_bus_pkg.sv
// Shared AHB-Lite encodings, digit-bridge state encoding and byte-lane masks.
// The ERR1/ERR2 states exist only when DIGIT_BRIDGE_ERR_RESP_EN is defined.
package prism_bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [3:0] LANE_NONE  = 4'b0000;
  localparam logic [3:0] LANE_BYTE0 = 4'b0001;
  localparam logic [3:0] LANE_HALF0 = 4'b0011;
  localparam logic [3:0] LANE_WORD  = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DATA  = 3'd1,
    ST_RD_DATA  = 3'd2,
`ifdef DIGIT_BRIDGE_ERR_RESP_EN
    ST_RD_STALL = 3'd3,
    ST_ERR1     = 3'd4,
    ST_ERR2     = 3'd5
`else
    ST_RD_STALL = 3'd3
`endif
  } bridge_state_t;

endpackage

// File: rtl/ahb_digit_bridge_if.sv
// AHB-Lite slave-side signal bundle for the digit bridge.
interface ahb_digit_bridge_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRDATA, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRDATA, HRESP
  );
endinterface

// File: rtl/byte_lane_decode.sv
// Combinational AHB size/offset to byte-lane mask decode, shared by bus peripherals.
// Misaligned half/word accesses and sizes wider than a word yield mask 0 and illegal=1.
module byte_lane_decode
  import prism_bus_pkg::*;
(
  input  logic [2:0] hsize,
  input  logic [1:0] addr_lo,
  output logic [3:0] mask,
  output logic       illegal
);

  always_comb begin
    mask    = LANE_NONE;
    illegal = 1'b0;
    case (hsize)
      HSIZE_BYTE: mask = LANE_BYTE0 << addr_lo;
      HSIZE_HALF: begin
        if (addr_lo[0]) illegal = 1'b1;
        else            mask = LANE_HALF0 << {addr_lo[1], 1'b0};
      end
      HSIZE_WORD: begin
        if (addr_lo != 2'b00) illegal = 1'b1;
        else                  mask = LANE_WORD;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ahb_digit_bridge.sv
// AHB-Lite slave bridge in front of the 7-segment digit register block.
// Define DIGIT_BRIDGE_ERR_RESP_EN to answer out-of-range/illegal transfers with a two-cycle ERROR.
module ahb_digit_bridge
  import prism_bus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  ahb_digit_bridge_if.slave  bus,
  output logic [ADDR_W-1:0]  addrIn,
  output logic [3:0]         sizeDecode,
  output logic [31:0]        dataIn,
  output logic [ADDR_W-1:0]  addrOut,
  input  logic [31:0]        dataOut
);

  localparam int unsigned DEPTH_U = DEPTH;

  bridge_state_t     state_reg;
  logic [ADDR_W-1:0] idx_reg;
  logic [ADDR_W-1:0] rd_idx_reg;
  logic [3:0]        mask_reg;
  logic              bad_reg;
  logic              hreadyout_reg;

  logic              valid;
  logic [ADDR_W-1:0] idx_now;
  logic [3:0]        lane_mask;
  logic              illegal_now;
  logic              oor_now;
  logic              bad_now;
  logic              raw_hazard;
  logic              unused_bits;

  byte_lane_decode u_lane (
    .hsize   (bus.HSIZE),
    .addr_lo (bus.HADDR[1:0]),
    .mask    (lane_mask),
    .illegal (illegal_now)
  );

  assign valid       = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign idx_now     = bus.HADDR[ADDR_W+1:2];
  assign oor_now     = (32'(idx_now) >= DEPTH_U);
  assign bad_now     = oor_now | illegal_now;
  assign unused_bits = ^{bus.HADDR[31:ADDR_W+2], bus.HTRANS[0]};

  // A read of the word being written this cycle would see the pre-write value
  // through the registered read port, so it is held for one extra cycle.
  assign raw_hazard = (state_reg == ST_WR_DATA) && !bad_reg &&
                      (mask_reg != LANE_NONE) && (idx_now == idx_reg);

`ifdef DIGIT_BRIDGE_ERR_RESP_EN
  logic hresp_reg;
  assign bus.HRESP = hresp_reg;
`else
  assign bus.HRESP = HRESP_OKAY;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      rd_idx_reg    <= '0;
      mask_reg      <= LANE_NONE;
      bad_reg       <= 1'b0;
      hreadyout_reg <= 1'b1;
`ifdef DIGIT_BRIDGE_ERR_RESP_EN
      hresp_reg     <= HRESP_OKAY;
`endif
    end else begin
      hreadyout_reg <= 1'b1;
`ifdef DIGIT_BRIDGE_ERR_RESP_EN
      hresp_reg     <= HRESP_OKAY;
`endif
      case (state_reg)
        ST_RD_STALL: state_reg <= ST_RD_DATA;
`ifdef DIGIT_BRIDGE_ERR_RESP_EN
        ST_ERR1: begin
          state_reg <= ST_ERR2;
          hresp_reg <= HRESP_ERROR;
        end
`endif
        default: begin
          if (valid) begin
            idx_reg  <= idx_now;
            mask_reg <= lane_mask;
            bad_reg  <= bad_now;
            if (!bus.HWRITE) rd_idx_reg <= idx_now;
          end
          if (!valid) begin
            state_reg <= ST_IDLE;
          end
`ifdef DIGIT_BRIDGE_ERR_RESP_EN
          else if (bad_now) begin
            state_reg     <= ST_ERR1;
            hreadyout_reg <= 1'b0;
            hresp_reg     <= HRESP_ERROR;
          end
`endif
          else if (bus.HWRITE) begin
            state_reg <= ST_WR_DATA;
          end else if (raw_hazard) begin
            state_reg     <= ST_RD_STALL;
            hreadyout_reg <= 1'b0;
          end else begin
            state_reg <= ST_RD_DATA;
          end
        end
      endcase
    end
  end

  assign bus.HREADYOUT = hreadyout_reg;
  assign bus.HRDATA    = (state_reg == ST_RD_DATA && !bad_reg) ? dataOut : 32'h0;

  // Lane enables come straight from state so an async reset drops them at once.
  assign sizeDecode = (state_reg == ST_WR_DATA && !bad_reg) ? mask_reg : LANE_NONE;
  assign addrIn     = idx_reg;
  assign dataIn     = bus.HWDATA;
  assign addrOut    = (valid && !bus.HWRITE) ? idx_now : rd_idx_reg;

endmodule

// File: tb/tb_ahb_digit_bridge.sv
// Scoreboard bench for ahb_digit_bridge with a behavioural digit-register peripheral.
// Expectations follow DIGIT_BRIDGE_ERR_RESP_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_ahb_digit_bridge;

`ifdef DIGIT_BRIDGE_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  localparam int DEPTH = 2;

  typedef struct {
    bit        sel;
    bit [1:0]  trans;
    bit        write;
    bit [31:0] addr;
    bit [2:0]  size;
    bit [31:0] wdata;
  } xfer_t;

  typedef struct {
    int        id;
    bit        write;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    bit        err;
    int        waits;
    bit [3:0]  lanes;
    bit [7:0]  idx;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  addr_in;
  logic [3:0]  size_decode;
  logic [31:0] data_in;
  logic [7:0]  addr_out;
  logic [31:0] data_out;
  logic [31:0] pmem [0:DEPTH-1];

  ahb_digit_bridge_if bus();
  assign bus.HREADY = bus.HREADYOUT;

  ahb_digit_bridge #(.ADDR_W(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .addrIn     (addr_in),
    .sizeDecode (size_decode),
    .dataIn     (data_in),
    .addrOut    (addr_out),
    .dataOut    (data_out)
  );

  always #5 clk = ~clk;

  // Digit register block: byte-lane writes, one-cycle registered read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) pmem[i] <= 32'h0;
    end else if (addr_in < 8'(DEPTH)) begin
      for (int b = 0; b < 4; b++)
        if (size_decode[b]) pmem[addr_in[0]][8*b +: 8] <= data_in[8*b +: 8];
    end
    data_out <= (addr_out < 8'(DEPTH)) ? pmem[addr_out[0]] : 32'hDEAD_BEEF;
  end

  int        n_checks = 0;
  int        n_fail   = 0;
  xfer_t     seq_q[$];
  exp_t      exp_q[$];
  bit [31:0] mem_model [0:DEPTH-1];
  bit        prev_wr_eff = 1'b0;
  bit [7:0]  prev_idx = 8'h0;
  int        next_id = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, want);
    end
  endtask

  task automatic add(input bit sel, input bit [1:0] trans, input bit write,
                     input bit [31:0] addr, input bit [2:0] size, input bit [31:0] wdata);
    xfer_t x;
    x.sel = sel; x.trans = trans; x.write = write;
    x.addr = addr; x.size = size; x.wdata = wdata;
    seq_q.push_back(x);
  endtask

  // Reference model: expected response for a transfer, computed when it is first driven.
  task automatic push_exp(input xfer_t x);
    exp_t e;
    int   nbytes;
    bit   legal, oor, bad, hazard;
    bit [3:0] lanes;
    e.id = next_id++; e.write = x.write; e.addr = x.addr; e.wdata = x.wdata;
    e.rdata = 0; e.err = 0; e.waits = 0; e.lanes = 0; e.idx = x.addr[9:2];
    if (!(x.sel && x.trans[1])) begin
      prev_wr_eff = 1'b0;
      exp_q.push_back(e);
      return;
    end
    nbytes = (x.size == 0) ? 1 : (x.size == 1) ? 2 : 4;
    legal  = (x.size <= 2) && ((x.addr % nbytes) == 0);
    oor    = (e.idx >= 8'(DEPTH));
    bad    = oor || !legal;
    lanes  = 4'b0;
    for (int b = 0; b < 4; b++)
      if (b >= int'(x.addr[1:0]) && b < int'(x.addr[1:0]) + nbytes) lanes[b] = 1'b1;
    if (bad) lanes = 4'b0;
    if (x.write) begin
      e.lanes = lanes;
      e.err   = bad && ERR_EN;
      e.waits = (bad && ERR_EN) ? 1 : 0;
      if (lanes != 0)
        for (int b = 0; b < 4; b++)
          if (lanes[b]) mem_model[e.idx[0]][8*b +: 8] = x.wdata[8*b +: 8];
    end else begin
      hazard  = prev_wr_eff && (prev_idx == e.idx);
      e.err   = bad && ERR_EN;
      e.waits = (bad && ERR_EN) ? 1 : (hazard ? 1 : 0);
      e.rdata = bad ? 32'h0 : mem_model[e.idx[0]];
    end
    prev_wr_eff = x.write && (lanes != 0);
    prev_idx    = e.idx;
    exp_q.push_back(e);
  endtask

  task automatic drive_addr(input xfer_t x);
    bus.HSEL = x.sel; bus.HTRANS = x.trans; bus.HWRITE = x.write;
    bus.HADDR = x.addr; bus.HSIZE = x.size;
  endtask

  task automatic drive_idle();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0;
    bus.HADDR = 32'h0; bus.HSIZE = 3'd0;
  endtask

  // Pipelined master: entered just after a rising edge, consumes seq_q.
  task automatic play();
    int   idx = 0;
    bit   dp_active = 1'b0;
    bit   presented = 1'b0;
    int   waits = 0;
    int   guard = 0;
    exp_t cur;
    while ((idx < seq_q.size() || dp_active) && guard < 1000) begin
      guard++;
      if (dp_active) bus.HWDATA = exp_q[0].wdata;
      if (!presented) begin
        if (idx < seq_q.size()) begin
          drive_addr(seq_q[idx]);
          push_exp(seq_q[idx]);
          presented = 1'b1;
        end else begin
          drive_idle();
        end
      end
      @(negedge clk);
      if (dp_active) begin
        cur = exp_q[0];
        if (!bus.HREADYOUT) begin
          waits++;
          check_eq($sformatf("t%0d_hresp_wait", cur.id), 32'(bus.HRESP), 32'(cur.err));
          check_eq($sformatf("t%0d_lanes_wait", cur.id), 32'(size_decode), 32'h0);
          if (waits > 4) begin
            check_eq($sformatf("t%0d_wait_bound", cur.id), 32'(waits), 32'(cur.waits));
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
          end
        end else begin
          check_eq($sformatf("t%0d_waits", cur.id), 32'(waits), 32'(cur.waits));
          check_eq($sformatf("t%0d_hresp", cur.id), 32'(bus.HRESP), 32'(cur.err));
          check_eq($sformatf("t%0d_hrdata", cur.id), bus.HRDATA, cur.rdata);
          check_eq($sformatf("t%0d_lanes", cur.id), 32'(size_decode), 32'(cur.lanes));
          if (cur.lanes != 0)
            check_eq($sformatf("t%0d_addrin", cur.id), 32'(addr_in), 32'(cur.idx));
          $display("xfer %0d %s addr=%h waits=%0d hresp=%0d hrdata=%h lanes=%b",
                   cur.id, cur.write ? "W" : "R", cur.addr, waits, bus.HRESP,
                   bus.HRDATA, size_decode);
          void'(exp_q.pop_front());
          dp_active = 1'b0;
        end
      end
      if (bus.HREADYOUT && presented) begin
        dp_active = 1'b1;
        presented = 1'b0;
        waits     = 0;
        idx++;
      end
      @(posedge clk);
      #1;
    end
    if (guard >= 1000) check_eq("play_bound", 32'(guard), 32'd0);
    seq_q.delete();
  endtask

  initial begin
    drive_idle();
    bus.HWDATA = 32'h0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check_eq("rst_hresp", 32'(bus.HRESP), 32'd0);
    check_eq("rst_hrdata", bus.HRDATA, 32'h0);
    check_eq("rst_lanes", 32'(size_decode), 32'h0);
    check_eq("rst_addrin", 32'(addr_in), 32'h0);
    check_eq("rst_addrout", 32'(addr_out), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    add(1, 2'b10, 1, 32'h00, 3'd2, 32'h0000_2F21);
    add(1, 2'b10, 0, 32'h00, 3'd2, 32'h0);
    add(1, 2'b10, 1, 32'h06, 3'd0, 32'h00AB_0000);
    add(1, 2'b10, 0, 32'h04, 3'd2, 32'h0);
    add(1, 2'b10, 1, 32'h06, 3'd0, 32'h00CD_0000);
    add(1, 2'b10, 0, 32'h00, 3'd2, 32'h0);
    add(1, 2'b10, 1, 32'h01, 3'd1, 32'h0000_5A5A);
    add(1, 2'b10, 0, 32'h00, 3'd2, 32'h0);
    add(1, 2'b10, 0, 32'h10, 3'd2, 32'h0);
    add(1, 2'b01, 0, 32'h00, 3'd2, 32'h0);
    add(1, 2'b00, 1, 32'h00, 3'd2, 32'hFFFF_FFFF);
    add(0, 2'b10, 1, 32'h00, 3'd2, 32'hFFFF_FFFF);
    add(1, 2'b10, 0, 32'h04, 3'd2, 32'h0);
    add(1, 2'b11, 1, 32'h06, 3'd1, 32'h1234_0000);
    add(1, 2'b11, 0, 32'h07, 3'd0, 32'h0);
    add(1, 2'b10, 1, 32'h0C, 3'd2, 32'h7777_7777);
    add(1, 2'b10, 0, 32'h0C, 3'd2, 32'h0);
    add(1, 2'b10, 1, 32'h02, 3'd2, 32'h9999_9999);
    add(1, 2'b10, 0, 32'h00, 3'd3, 32'h0);
    add(1, 2'b10, 1, 32'h05, 3'd0, 32'h0000_EE00);
    add(1, 2'b10, 0, 32'h00, 3'd2, 32'h0);
    add(1, 2'b10, 0, 32'h04, 3'd2, 32'h0);
    play();

    // Reset asserted in the middle of a write data phase.
    drive_addr('{sel: 1'b1, trans: 2'b10, write: 1'b1, addr: 32'h0, size: 3'd2, wdata: 32'h1111_1111});
    @(negedge clk);
    @(posedge clk);
    #1;
    bus.HWDATA = 32'h1111_1111;
    drive_idle();
    #1;
    check_eq("rstmid_lanes_before", 32'(size_decode), 32'hF);
    rst = 1'b1;
    #1;
    check_eq("rstmid_lanes", 32'(size_decode), 32'h0);
    check_eq("rstmid_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check_eq("rstmid_hresp", 32'(bus.HRESP), 32'd0);
    check_eq("rstmid_hrdata", bus.HRDATA, 32'h0);
    check_eq("rstmid_addrin", 32'(addr_in), 32'h0);
    check_eq("rstmid_addrout", 32'(addr_out), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_model[i] = 32'h0;
    prev_wr_eff = 1'b0;

    add(1, 2'b10, 1, 32'h04, 3'd2, 32'hCAFE_F00D);
    add(1, 2'b10, 0, 32'h04, 3'd2, 32'h0);
    add(1, 2'b10, 0, 32'h00, 3'd2, 32'h0);
    play();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
